// File: rtl/core_pkg.sv
// core_pkg
// Shared types and constants for the RV32I pipeline control blocks.
//   state_e   : pipeline sequencer states (HOLD / RUN / FREEZE)
//   REG_IDX_W : width of an architectural register index
package core_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } state_e;

  localparam int REG_IDX_W = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk, rst : clock, asynchronous active-low reset (clears q)
//   inc      : count up by one this cycle (ignored once saturated)
//   clr      : synchronous clear, wins over inc
//   q        : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline sequencer for the 5-stage core: reset hold, load-use stall,
// taken-branch flush, data-memory freeze, debug counters.
//   inputs : clk, rst (async active-low), id_valid, id_rs1, id_rs2, ex_rd,
//            ex_MemRead, branch_taken_ex, mem_busy
//   outputs: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
//            memwb_en, pipe_ready, stall_cnt, flush_cnt, freeze_timeout
//
// state  | meaning
// HOLD   | post-reset idle, pipe flushed, waiting for hold counter to hit 0
// RUN    | normal operation, hazard/branch controls from the inputs
// FREEZE | data memory busy, whole pipe held
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int RESET_HOLD = 4,
  parameter int FREEZE_MAX = 255,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_MemRead,
  input  logic                 branch_taken_ex,
  input  logic                 mem_busy,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_flush,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 pipe_ready,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic                 freeze_timeout
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
  // One spare count above FREEZE_MAX so the saturated value still exceeds it.
  localparam int FRZ_W = $clog2(FREEZE_MAX + 2);
  localparam logic [FRZ_W-1:0] FRZ_LIMIT = FRZ_W'(FREEZE_MAX);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_timeout;
  logic [FRZ_W-1:0]  w_frz_cnt;
  logic              w_frozen;
  logic              w_stall_inc;
  logic              w_flush_inc;
  logic              w_load_use;

  assign w_load_use = ex_MemRead && (ex_rd != '0) && id_valid &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= HOLD;
      r_hold_cnt <= HOLD_INIT;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == HOLD) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
      // Counter still holds the previous frozen-cycle count, so >= here means
      // this cycle is frozen cycle number FREEZE_MAX+1 or later.
      if (w_frozen && (w_frz_cnt >= FRZ_LIMIT)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    w_frozen    = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    case (r_state)
      HOLD: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (r_hold_cnt == '0) w_state_nxt = RUN;
      end
      // FREEZE with mem_busy low is its exit cycle and follows RUN rules,
      // so both states share the same decode.
      RUN, FREEZE: begin
        if (mem_busy) begin
          w_frozen    = 1'b1;
          w_state_nxt = FREEZE;
        end else begin
          w_state_nxt = RUN;
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
          memwb_en    = 1'b1;
          if (branch_taken_ex) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            w_flush_inc = 1'b1;
          end else if (w_load_use) begin
            idex_flush  = 1'b1;
            w_stall_inc = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = HOLD;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall_inc),
    .clr (1'b0),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_flush_inc),
    .clr (1'b0),
    .q   (flush_cnt)
  );

  sat_counter #(.W(FRZ_W)) u_frz_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_frozen),
    .clr (!w_frozen),
    .q   (w_frz_cnt)
  );

  assign pipe_ready     = (r_state != HOLD);
  assign freeze_timeout = r_timeout;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage RV32I core. It sits beside the decode stage and drives the enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards against the instruction in decode and flushes wrong-path instructions on a taken branch. It also freezes the whole pipe while data memory is busy and holds the pipe idle for a fixed number of cycles after reset. Performance counters and a sticky freeze-timeout flag are kept for debug.

## Interface
Parameters:
- RESET_HOLD, 4, cycles the pipe stays idle after reset deassertion (≥1)
- FREEZE_MAX, 255, consecutive freeze cycles tolerated before freeze_timeout sets
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous assert, active-low
- id_valid  in  1  IF/ID holds a real instruction
- id_rs1  in  5  decode source register 1
- id_rs2  in  5  decode source register 2
- ex_rd  in  5  destination register of the instruction in ID/EX
- ex_MemRead  in  1  instruction in ID/EX is a load
- branch_taken_ex  in  1  EX resolved a taken branch this cycle
- mem_busy  in  1  data memory not ready; the pipe must hold
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to bubble
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX clear to bubble (RegWrite/MemRead/MemWrite/Branch = 0)
- exmem_en  out  1  EX/MEM load enable
- memwb_en  out  1  MEM/WB load enable
- pipe_ready  out  1  reset hold complete
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  branch flush events, saturating
- freeze_timeout  out  1  sticky; set when a freeze exceeds FREEZE_MAX cycles

## Operation
- States: HOLD, RUN, FREEZE.
- HOLD: entered on reset. A down-counter is loaded with RESET_HOLD−1 and stays in HOLD until the counter reaches 0, then moves to RUN.
  - In HOLD, all enables are 0, ifid_flush = idex_flush = 1 and pipe_ready = 0.
- RUN: controls are combinational from the inputs, in this priority order:
  1. mem_busy: go to FREEZE. The current cycle is already frozen, with all enables 0 and no flushes.
  2. branch_taken_ex: ifid_flush = idex_flush = 1 and all enables = 1. flush_cnt increments.
  3. Load-use, defined as ex_MemRead ∧ ex_rd≠0 ∧ id_valid ∧ (ex_rd==id_rs1 ∨ ex_rd==id_rs2):
     - pc_en = ifid_en = 0 and idex_flush = 1.
     - idex_en, exmem_en and memwb_en = 1.
     - stall_cnt increments.
  4. Otherwise: all enables = 1 and no flushes.
- FREEZE: all enables 0, no flushes, and the counters do not change. A freeze counter increments each cycle.
  - If the freeze counter exceeds FREEZE_MAX, freeze_timeout sets. It clears only on reset.
  - When mem_busy = 0, return to RUN. That cycle is evaluated with RUN rules.
  - A branch or load-use visible on exit is therefore handled in the exit cycle. EX contents were held during the freeze, so branch_taken_ex persists.
- Counters saturate at all-ones and do not wrap.
- Load-use with id_rs1 or id_rs2 = x0 but ex_rd≠0 does not stall unless the indices match. ex_rd = 0 never stalls.

## Timing
- Reset (rst = 0) takes effect immediately, asynchronously:
  - state = HOLD, hold counter = RESET_HOLD−1, freeze counter = 0.
  - stall_cnt = flush_cnt = 0, freeze_timeout = 0, pipe_ready = 0.
  - All enables 0, ifid_flush = idex_flush = 1.
- After rst rises, pipe_ready asserts exactly RESET_HOLD clock edges later. The first enabled fetch occurs in that cycle.
- A load-use stall lasts exactly 1 cycle. In the following cycle ex_MemRead is 0 because of the bubble, so the hazard clears.
- Branch flush has zero cycles of latency: the flushes are asserted in the same cycle as branch_taken_ex.
- Branch and load-use in the same cycle: the branch wins, and no stall is counted.
- mem_busy and branch in the same cycle: the freeze wins, and the branch is handled on exit.
- Reset in mid-freeze or mid-stall aborts the operation and returns to HOLD.

## Structure
- Shared package core_pkg:
  - state enum: HOLD = 2'd0, RUN = 2'd1, FREEZE = 2'd2.
  - Register-index width constant: 5.
- Sub-module sat_counter (parameter W; ports inc, clr, q) is instantiated for stall_cnt, flush_cnt and the freeze counter.
- The FSM and the hazard compare stay in pipe_hazard_ctrl.

## Test plan
- **Reset hold:** hold rst low for 3 cycles, then release.
  - pipe_ready rises at edge 4 with RESET_HOLD = 4.
  - Before that, pc_en = 0 and ifid_flush = idex_flush = 1.
- **Load-use stall:** ex_MemRead = 1, ex_rd = 5, id_rs2 = 5, id_valid = 1.
  - In one cycle: pc_en = ifid_en = 0 and idex_flush = 1, and stall_cnt goes 0→1.
  - With ex_rd = 0 there is no stall.
- **Branch over load-use:** branch_taken_ex = 1 together with a load-use match.
  - ifid_flush = idex_flush = 1 and pc_en = 1.
  - flush_cnt increments and stall_cnt is unchanged.
- **Freeze:** assert mem_busy for 10 cycles with branch_taken_ex held high.
  - All enables are 0 for 10 cycles.
  - The flush fires in the first cycle with mem_busy = 0, and flush_cnt increments by 1.
- **Timeout:** with FREEZE_MAX = 8, hold mem_busy for 9 cycles.
  - freeze_timeout sets on cycle 9 and stays set after mem_busy drops, until rst.
- **Saturation and reset mid-freeze:** with CNT_W = 2, cause 5 stalls, then pulse rst low during a freeze.
  - stall_cnt reads 3 after the fifth stall.
  - The rst pulse returns the block to HOLD and clears all counters.
